// File: rtl/serializador_32_if.sv
// -----------------------------------------------------------------------------
// serializador_32_if
// Bundle of the transmit-side handshake and serial link signals.
//   enable      shift tick shared with the receiver (driven by master)
//   data_in     parallel word to transmit            (driven by master)
//   load_valid  data_in is valid                     (driven by master)
//   load_ready  serializer can accept a word         (driven by slave)
//   serial_out  current serial bit                   (driven by slave)
//   frame       serial_out carries word bits         (driven by slave)
//   done        one-cycle pulse after the last bit   (driven by slave)
// -----------------------------------------------------------------------------
interface serializador_32_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             frame;
    logic             done;

    modport master (
        output enable, data_in, load_valid,
        input  load_ready, serial_out, frame, done
    );

    modport slave (
        input  enable, data_in, load_valid,
        output load_ready, serial_out, frame, done
    );
endinterface

// File: rtl/serializador_32.sv
// -----------------------------------------------------------------------------
// serializador_32
// Parallel-in, serial-out transmitter. A word is accepted through the
// load_valid/load_ready handshake and shifted out one bit per enable tick,
// MSB first unless MSB_FIRST is 0. frame is high while word bits are on
// serial_out; done pulses for one cycle in the first idle cycle after the
// last bit.
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      serializador_32_if.slave (enable, data_in, load_valid in;
//            load_ready, serial_out, frame, done out)
// -----------------------------------------------------------------------------
module serializador_32 #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic              clock,
    input logic              reset_n,
    serializador_32_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             done_q,  done_d;

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // enable is deliberately ignored here, even on the accept
                // edge, so the first bit always gets a full bit period.
                if (bus.load_valid) begin
                    sreg_d  = bus.data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // load_valid is ignored while busy: no queuing, no corruption.
                if (bus.enable) begin
                    if (MSB_FIRST) begin
                        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                    end

                    if (cnt_q == LAST_BIT) begin
                        // Park the counter at 0 rather than letting it wrap.
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state elements use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Outputs are decoded from registered state only, so they settle
    // immediately on reset assertion without waiting for a clock edge.
    always_comb begin
        bus.load_ready = (state_q == IDLE);
        bus.frame      = (state_q == SHIFT);
        bus.done       = done_q;
        bus.serial_out = 1'b0;
        if (state_q == SHIFT) begin
            bus.serial_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        end
    end
endmodule

// File: tb/tb_serializador_32.sv
// -----------------------------------------------------------------------------
// tb_serializador_32
// Self-checking bench for serializador_32. An MSB-first and an LSB-first
// instance share clock and reset. Expected bits are taken straight from the
// transmitted word; a behavioural 32-bit receiver clocked by the shared
// enable confirms each word arrives intact.
// -----------------------------------------------------------------------------
module tb_serializador_32;
    localparam int W = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    serializador_32_if #(.WIDTH(W)) bus();
    serializador_32_if #(.WIDTH(W)) bus_l();

    serializador_32 #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    serializador_32 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_l)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference receiver: shifts serial_out in MSB first on each enable edge.
    logic [W-1:0] rx_q = '0;
    always @(posedge clock) begin
        if (bus.enable) rx_q <= {rx_q[W-2:0], bus.serial_out};
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Idle for n cycles with the given enable level; outputs must stay idle.
    task automatic idle_cycles(input int n, input bit en);
        for (int i = 0; i < n; i++) begin
            bus.enable     = en;
            bus.load_valid = 1'b0;
            bus.data_in    = W'($urandom);
            @(negedge clock);
            check("idle_frame", bus.frame, 1'b0);
            check("idle_done", bus.done, 1'b0);
            check("idle_ready", bus.load_ready, 1'b1);
            check("idle_serial", bus.serial_out, 1'b0);
        end
        bus.enable = 1'b0;
    endtask

    // Send one word on the MSB-first instance. Enable fires every gap-th
    // cycle after accept. collide keeps load_valid high with the inverted
    // word during the frame. Entered just after a negedge with the DUT idle;
    // returns at the negedge where done must be high.
    task automatic send_word(input logic [W-1:0] word, input int gap,
                             input bit collide, input bit en_on_accept);
        bit exp_bits[$];
        bit b;
        bit en;
        int phase = 0;

        for (int k = 0; k < W; k++) exp_bits.push_back(word[W-1-k]);

        check("ready_before_accept", bus.load_ready, 1'b1);
        bus.data_in    = word;
        bus.load_valid = 1'b1;
        bus.enable     = en_on_accept;
        @(negedge clock);
        check("done_cleared", bus.done, 1'b0);
        bus.load_valid = collide;
        bus.data_in    = collide ? ~word : W'($urandom);

        while (exp_bits.size() > 0) begin
            b = exp_bits.pop_front();
            do begin
                check("serial_bit", bus.serial_out, b);
                check("frame_high", bus.frame, 1'b1);
                check("ready_low", bus.load_ready, 1'b0);
                phase++;
                en         = (phase % gap) == 0;
                bus.enable = en;
                @(negedge clock);
                if (!collide) bus.data_in = W'($urandom);
            end while (!en);
        end

        bus.load_valid = 1'b0;
        bus.enable     = 1'b0;
        check("end_frame", bus.frame, 1'b0);
        check("end_done", bus.done, 1'b1);
        check("end_ready", bus.load_ready, 1'b1);
        check("end_serial", bus.serial_out, 1'b0);
        check("rx_word", rx_q, word);
    endtask

    initial begin
        logic [W-1:0] lsb_word;

        bus.enable       = 1'b0;
        bus.load_valid   = 1'b0;
        bus.data_in      = '0;
        bus_l.enable     = 1'b0;
        bus_l.load_valid = 1'b0;
        bus_l.data_in    = '0;

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_ready", bus.load_ready, 1'b1);
        check("rst_frame", bus.frame, 1'b0);
        check("rst_serial", bus.serial_out, 1'b0);
        check("rst_done", bus.done, 1'b0);
        reset_n = 1'b1;

        // enable alone in IDLE does nothing.
        idle_cycles(3, 1'b1);

        // Continuous enable.
        send_word(32'hA5A5_0F0F, 1, 1'b0, 1'b0);
        idle_cycles(1, 1'b0);

        // Gapped enable: one tick every third cycle, 96-cycle frame.
        send_word(32'h8000_0000, 3, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);

        // load_valid while busy is ignored; then valid+enable in IDLE
        // on the done cycle (back-to-back accept).
        send_word(32'h0000_0000, 1, 1'b1, 1'b0);
        send_word(W'($urandom), 1, 1'b0, 1'b1);
        idle_cycles(1, 1'b0);

        // Reset mid-frame with bit 10 on the line.
        bus.data_in    = W'($urandom);
        bus.load_valid = 1'b1;
        @(negedge clock);
        bus.load_valid = 1'b0;
        bus.enable     = 1'b1;
        repeat (10) @(negedge clock);
        check("midframe_frame", bus.frame, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_rst_frame", bus.frame, 1'b0);
        check("async_rst_serial", bus.serial_out, 1'b0);
        check("async_rst_done", bus.done, 1'b0);
        check("async_rst_ready", bus.load_ready, 1'b1);
        bus.enable = 1'b0;
        @(negedge clock);
        check("held_rst_done", bus.done, 1'b0);
        reset_n = 1'b1;
        send_word(32'h0000_0001, 1, 1'b0, 1'b0);
        idle_cycles(1, 1'b0);

        // LSB-first instance: fixed word then a random one.
        for (int t = 0; t < 2; t++) begin
            lsb_word = (t == 0) ? 32'h0000_0003 : W'($urandom);
            bus_l.data_in    = lsb_word;
            bus_l.load_valid = 1'b1;
            bus_l.enable     = 1'b0;
            @(negedge clock);
            bus_l.load_valid = 1'b0;
            bus_l.enable     = 1'b1;
            for (int k = 0; k < W; k++) begin
                check("lsb_bit", bus_l.serial_out, lsb_word[k]);
                check("lsb_frame", bus_l.frame, 1'b1);
                @(negedge clock);
            end
            bus_l.enable = 1'b0;
            check("lsb_done", bus_l.done, 1'b1);
            check("lsb_frame_end", bus_l.frame, 1'b0);
            @(negedge clock);
            check("lsb_done_clear", bus_l.done, 1'b0);
        end

        // Loopback: 1000 random words back-to-back, period WIDTH+1.
        for (int i = 0; i < 1000; i++) begin
            send_word(W'($urandom), 1, 1'b0, 1'($urandom_range(0, 1)));
        end
        idle_cycles(1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
